// File: rtl/gmac_uni_param.sv
// rtl/gmac_uni_param.sv - unary gated-multiply OR-accumulate over NCH channels in an N=2^WIDTH cycle window
// Optional oCnt accumulator is built only when GMAC_UNI_PARAM_CNT_EN is defined.
module gmac_uni_param #(
    parameter int WIDTH = 8,
    parameter int NCH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] iA,
    input  logic [NCH*WIDTH-1:0] iB,
    input  logic                 loadA,
    input  logic                 loadB,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 oC,
    output logic [WIDTH:0]       oCnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [WIDTH-1:0] GEN_ONE = 1;

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic             oc_q;
    logic [WIDTH-1:0] reg_a_q [NCH];
    logic [WIDTH-1:0] reg_b_q [NCH];
    logic [WIDTH-1:0] cnt_a_q [NCH];
    logic [WIDTH-1:0] cnt_b_q [NCH];

    logic [NCH-1:0]   a_bit;
    logic [NCH-1:0]   b_bit;
    logic             prod_or;
    logic             last_idx;
    logic             start_acc;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int k = 0; k < WIDTH; k++) begin
            r[k] = v[WIDTH-1-k];
        end
        return r;
    endfunction

    always_comb begin
        a_bit = '0;
        b_bit = '0;
        for (int i = 0; i < NCH; i++) begin
            a_bit[i] = reg_a_q[i] > bit_rev(cnt_a_q[i]);
            b_bit[i] = reg_b_q[i] > bit_rev(cnt_b_q[i]);
        end
        prod_or = |(a_bit & b_bit);
    end

    // cntA advances identically in every channel, so channel 0 doubles as the compute index.
    assign last_idx  = (cnt_a_q[0] == {WIDTH{1'b1}});
    assign start_acc = (state_q == S_IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            oc_q    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                reg_a_q[i] <= '0;
                reg_b_q[i] <= '0;
                cnt_a_q[i] <= '0;
                cnt_b_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                if (loadA) reg_a_q[i] <= iA[i*WIDTH +: WIDTH];
                if (loadB) reg_b_q[i] <= iB[i*WIDTH +: WIDTH];
            end
            case (state_q)
                S_IDLE: begin
                    oc_q <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < NCH; i++) begin
                            cnt_a_q[i] <= '0;
                            cnt_b_q[i] <= '0;
                        end
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    oc_q <= prod_or;
                    for (int i = 0; i < NCH; i++) begin
                        cnt_a_q[i] <= cnt_a_q[i] + GEN_ONE;
                        if (a_bit[i]) cnt_b_q[i] <= cnt_b_q[i] + GEN_ONE;
                    end
                    if (last_idx) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    oc_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    oc_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef GMAC_UNI_PARAM_CNT_EN
    localparam logic [WIDTH:0] CNT_ONE = 1;
    logic [WIDTH:0] ocnt_q;

    // busy still covers the drain edge, so the last computed bit is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ocnt_q <= '0;
        end else if (start_acc) begin
            ocnt_q <= '0;
        end else if (busy_q && oc_q) begin
            ocnt_q <= ocnt_q + CNT_ONE;
        end
    end

    assign oCnt = ocnt_q;
`else
    assign oCnt = '0;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign oC   = oc_q;

endmodule

// File: tb/tb_gmac_uni_param.sv
// tb/tb_gmac_uni_param.sv - randomized and directed bench for gmac_uni_param against a stream-level model
module tb_gmac_uni_param;

    localparam int WIDTH = 8;
    localparam int NCH   = 16;
    localparam int N     = 1 << WIDTH;
`ifdef GMAC_UNI_PARAM_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH*WIDTH-1:0] iA, iB;
    logic                 loadA, loadB, start;
    logic                 busy, done, oC;
    logic [WIDTH:0]       oCnt;

    int tests = 0;
    int fails = 0;

    int opA [NCH];
    int opB [NCH];
    bit exp_bits [N];
    int exp_cnt;

    gmac_uni_param #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .iA(iA), .iB(iB),
        .loadA(loadA), .loadB(loadB), .start(start),
        .busy(busy), .done(done), .oC(oC), .oCnt(oCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int rev(input int v);
        int r = 0;
        for (int k = 0; k < WIDTH; k++) r = (r << 1) | ((v >> k) & 1);
        return r;
    endfunction

    // Each channel emits A and B unary streams; B's generator only steps when A's bit is 1.
    task automatic build_model();
        int cb [NCH];
        exp_cnt = 0;
        for (int ch = 0; ch < NCH; ch++) cb[ch] = 0;
        for (int c = 0; c < N; c++) begin
            exp_bits[c] = 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                bit a, b;
                a = opA[ch] > rev(c);
                b = opB[ch] > rev(cb[ch]);
                if (a) cb[ch]++;
                if (a && b) exp_bits[c] = 1'b1;
            end
            exp_cnt += exp_bits[c];
        end
    endtask

    task automatic clear_ops();
        for (int ch = 0; ch < NCH; ch++) begin
            opA[ch] = 0;
            opB[ch] = 0;
        end
    endtask

    task automatic arm(input bit do_load);
        if (do_load) begin
            for (int ch = 0; ch < NCH; ch++) begin
                iA[ch*WIDTH +: WIDTH] = opA[ch][WIDTH-1:0];
                iB[ch*WIDTH +: WIDTH] = opB[ch][WIDTH-1:0];
            end
        end
        loadA = do_load;
        loadB = do_load;
        start = 1'b1;
        build_model();
    endtask

    // Called at a negedge with arm() already applied; returns at the negedge of the done cycle.
    task automatic do_run(input bit mid_start, input int spec_cnt);
        @(negedge clk);
        start = 1'b0; loadA = 1'b0; loadB = 1'b0;
        check("busy_at_idx0", busy, 1);
        check("oc_at_idx0", oC, 0);
        check("ocnt_cleared", oCnt, 0);
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            start = (mid_start && k == 50);
            check($sformatf("oc_c%0d", k-1), oC, exp_bits[k-1]);
            check($sformatf("busy_k%0d", k), busy, 1);
            check($sformatf("done_early_k%0d", k), done, 0);
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", done, 1);
        check("busy_clear", busy, 0);
        check("oc_idle", oC, 0);
        check("ocnt_model", oCnt, CNT_EN ? exp_cnt : 0);
        if (spec_cnt >= 0) check("ocnt_spec", oCnt, CNT_EN ? spec_cnt : 0);
    endtask

    initial begin
        bit saw_done;
        rst_n = 1'b0; iA = '0; iB = '0; loadA = 1'b0; loadB = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_oc", oC, 0);
        check("rst_ocnt", oCnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        clear_ops(); arm(1'b1); do_run(1'b0, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        clear_ops(); opA[0] = 128; opB[0] = 128; arm(1'b1); do_run(1'b0, 64);
        clear_ops(); opA[0] = 255; opB[0] = 255; arm(1'b1); do_run(1'b0, 255);
        clear_ops(); opA[0] = 64; opB[0] = 255; opA[1] = 255; opB[1] = 255;
        arm(1'b1); do_run(1'b0, 255);
        clear_ops(); opA[0] = 128; opB[0] = 128; opA[1] = 128; opB[1] = 128;
        arm(1'b1); do_run(1'b1, 64);

        // Start taken in the done cycle, with fresh operands loaded on the same edge.
        clear_ops();
        for (int ch = 0; ch < NCH; ch++) begin
            opA[ch] = $urandom_range(0, 255);
            opB[ch] = $urandom_range(0, 255);
        end
        arm(1'b1); do_run(1'b0, -1);

        clear_ops(); opA[0] = 200; opB[0] = 180; opA[5] = 33; opB[5] = 250;
        arm(1'b1);
        @(negedge clk);
        start = 1'b0; loadA = 1'b0; loadB = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_oc", oC, 0);
        check("midrst_ocnt", oCnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < N + 4; k++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 0);

        clear_ops(); arm(1'b0); do_run(1'b0, 0);
        clear_ops(); opA[0] = 128; opB[0] = 128; arm(1'b1); do_run(1'b0, 64);

        for (int t = 0; t < 4; t++) begin
            clear_ops();
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 3) == 0) begin
                    opA[ch] = $urandom_range(0, 255);
                    opB[ch] = $urandom_range(0, 255);
                end
            end
            arm(1'b1); do_run(1'b0, -1);
        end

        @(negedge clk);
        check("final_idle", busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
